// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART TX byte interface between NUM_REQ byte-stream requesters.
//   Round-robin arbitration; the winner holds the lock for a whole message.
//   The lock drops after an end-of-message byte is accepted, or after the
//   holder has been idle (no valid byte) for TIMEOUT cycles.
//   The output byte is registered (tx_valid/tx_data).
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid[NUM_REQ]     per-requester byte valid
//   req_data[8*NUM_REQ]    per-requester byte, requester i at [8i+7:8i]
//   req_ready[NUM_REQ]     per-requester accept (holder only)
//   tx_valid, tx_data      registered byte to UART
//   tx_ready               UART accepts byte
//   grant[NUM_REQ]         one-hot lock holder, 0 when idle
//   busy                   lock held or output register occupied
module uart_tx_arbiter #(
  parameter int         NUM_REQ  = 2,
  parameter int         EOM_EN   = 1,
  parameter logic [7:0] EOM_BYTE = 8'h0A,
  parameter int         TIMEOUT  = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] g_idx;
  logic [CW-1:0] idle_cnt;

  // Round-robin pick: first valid requester after 'last', wrapping.
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  always_comb begin
    int c;
    pick_found = 1'b0;
    pick_idx   = '0;
    c          = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(last) + k) % NUM_REQ;
      if (!pick_found && req_valid[c]) begin
        pick_found = 1'b1;
        pick_idx   = c[IW-1:0];
      end
    end
  end

  // Output slot can take a byte when empty or draining this cycle.
  logic       slot_free;
  logic       hold_valid;
  logic [7:0] hold_data;
  logic       xfer;

  assign slot_free  = !tx_valid || tx_ready;
  assign hold_valid = |(req_valid & grant);
  assign hold_data  = req_data[int'(g_idx)*8 +: 8];
  assign xfer       = (state == LOCKED) && hold_valid && slot_free;

  assign req_ready  = (state == LOCKED && slot_free) ? grant : '0;
  assign busy       = (state == LOCKED) || tx_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IW'(NUM_REQ - 1);
      g_idx    <= '0;
      grant    <= '0;
      idle_cnt <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      // Output register: refill wins over drain.
      if (xfer) begin
        tx_valid <= 1'b1;
        tx_data  <= hold_data;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= LOCKED;
            g_idx    <= pick_idx;
            grant    <= NUM_REQ'(1) << pick_idx;
            idle_cnt <= '0;
          end
        end
        LOCKED: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (EOM_EN != 0 && hold_data == EOM_BYTE) begin
              state <= IDLE;
              grant <= '0;
              last  <= g_idx;
            end
          end else if (!hold_valid) begin
            // Stalled-by-UART holders still have valid high, so they never get here.
            if (idle_cnt == CW'(TIMEOUT - 1)) begin
              state    <= IDLE;
              grant    <= '0;
              last     <= g_idx;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int TO = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;

  uart_tx_arbiter #(.NUM_REQ(N), .EOM_EN(1), .EOM_BYTE(8'h0A), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Requester byte queues and handshake log {src, byte}.
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [15:0] log_q[$];

  // Stimulus knobs for the next cycle.
  logic [N-1:0] en;
  logic         rdy_in;
  logic         rst_in;
  bit           armed = 0;

  // Reference model: holder index (-1 = nobody), rotation pointer, idle
  // counter, and the output byte slot.
  int         m_hold, m_last, m_idle;
  bit         m_ov;
  logic [7:0] m_od;

  task automatic model_reset();
    m_hold = -1; m_last = N - 1; m_idle = 0; m_ov = 0; m_od = 8'h00;
  endtask

  task automatic model_step();
    bit         free, xf, found;
    logic [7:0] b;
    int         c;
    if (rst) begin
      model_reset();
      return;
    end
    free = !m_ov || tx_ready;
    xf   = (m_hold >= 0) && req_valid[m_hold] && free;
    b    = (m_hold >= 0) ? req_data[m_hold*8 +: 8] : 8'h00;
    if (xf) begin m_ov = 1; m_od = b; end
    else if (tx_ready) m_ov = 0;
    if (m_hold < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && req_valid[c]) begin found = 1; m_hold = c; end
      end
      m_idle = 0;
    end else if (xf) begin
      m_idle = 0;
      if (b == 8'h0A) begin m_last = m_hold; m_hold = -1; end
    end else if (!req_valid[m_hold]) begin
      if (m_idle == TO - 1) begin m_last = m_hold; m_hold = -1; m_idle = 0; end
      else m_idle++;
    end
  endtask

  // One clock: drive at negedge, compare against model, update model.
  task automatic cyc();
    logic [N-1:0] eg, er;
    @(negedge clk);
    rst      = rst_in;
    tx_ready = rdy_in;
    req_valid[0] = en[0] && (q0.size() > 0);
    req_valid[1] = en[1] && (q1.size() > 0);
    req_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
    req_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    #1;
    if (armed) begin
      eg = (m_hold < 0) ? '0 : N'(1) << m_hold;
      er = (m_hold >= 0 && (!m_ov || tx_ready)) ? eg : '0;
      chk("m_grant", 32'(grant), 32'(eg));
      chk("m_ready", 32'(req_ready), 32'(er));
      chk("m_txv",   32'(tx_valid), 32'(m_ov));
      chk("m_txd",   32'(tx_data), 32'(m_od));
      chk("m_busy",  32'(busy), 32'((m_hold >= 0) || m_ov));
    end
    armed = 1;
    if (!rst) begin
      if (req_valid[0] && req_ready[0]) begin log_q.push_back({8'd0, q0[0]}); void'(q0.pop_front()); end
      if (req_valid[1] && req_ready[1]) begin log_q.push_back({8'd1, q1[0]}); void'(q1.pop_front()); end
    end
    model_step();
  endtask

  task automatic do_reset(input int n);
    q0.delete(); q1.delete(); log_q.delete();
    rst_in = 1; en = '0; rdy_in = 1;
    repeat (n) cyc();
    rst_in = 0;
  endtask

  int cnt;
  bit hit;
  logic [7:0] cap;

  initial begin
    rst = 1; req_valid = '0; req_data = '0; tx_ready = 1;
    rst_in = 1; en = '0; rdy_in = 1;
    model_reset();

    // Reset with both requesters asserting valid.
    q0.push_back(8'h11); q1.push_back(8'h22); en = 2'b11;
    cyc();
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_txv", 32'(tx_valid), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_ready", 32'(req_ready), 0);
    end
    rst_in = 0;
    cyc();
    chk("post_rst_txv", 32'(tx_valid), 0);
    chk("post_rst_grant", 32'(grant), 0);
    chk("post_rst_ready", 32'(req_ready), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // Single message "Hi\n" from requester 0.
    do_reset(2);
    q0.push_back(8'h48); q0.push_back(8'h69); q0.push_back(8'h0A);
    en = 2'b01; rdy_in = 1;
    cyc(); chk("hi_idle_grant", 32'(grant), 0);
    cyc(); chk("hi_grant", 32'(grant), 2'b01); chk("hi_ready", 32'(req_ready), 2'b01);
    cyc(); chk("hi_tx0", 32'({tx_valid, tx_data}), {1'b1, 8'h48});
    cyc(); chk("hi_tx1", 32'({tx_valid, tx_data}), {1'b1, 8'h69});
    cyc(); chk("hi_tx2", 32'({tx_valid, tx_data}), {1'b1, 8'h0A});
    chk("hi_rel_grant", 32'(grant), 0);
    cyc(); chk("hi_drained", 32'(tx_valid), 0); chk("hi_busy", 32'(busy), 0);

    // Contention: two messages queued on req0, one on req1.
    do_reset(2);
    q0.push_back(8'h41); q0.push_back(8'h0A); q0.push_back(8'h41); q0.push_back(8'h0A);
    q1.push_back(8'h41); q1.push_back(8'h0A);
    en = 2'b11; rdy_in = 1;
    repeat (20) cyc();
    chk("rr_count", 32'(log_q.size()), 6);
    if (log_q.size() == 6) begin
      chk("rr_0", 32'(log_q[0]), 16'h0041);
      chk("rr_1", 32'(log_q[1]), 16'h000A);
      chk("rr_2", 32'(log_q[2]), 16'h0141);
      chk("rr_3", 32'(log_q[3]), 16'h010A);
      chk("rr_4", 32'(log_q[4]), 16'h0041);
      chk("rr_5", 32'(log_q[5]), 16'h000A);
    end

    // Backpressure mid-message; stall must not count toward timeout.
    do_reset(2);
    q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h43); q0.push_back(8'h0A);
    en = 2'b01; rdy_in = 1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin cyc(); hit = tx_valid; end
    chk("bp_start_to", 32'(hit), 1);
    rdy_in = 0;
    cyc(); cap = tx_data;
    chk("bp_txv", 32'(tx_valid), 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_stable", 32'(tx_data), 32'(cap));
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_grant", 32'(grant), 2'b01);
    end
    rdy_in = 1;
    repeat (10) cyc();
    chk("bp_all", 32'(log_q.size()), 4);
    chk("bp_idle", 32'(busy), 0);

    // Idle timeout: req0 sends one byte then goes quiet, req1 waiting.
    do_reset(2);
    q0.push_back(8'h41); q1.push_back(8'h42); q1.push_back(8'h0A);
    en = 2'b11; rdy_in = 1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin cyc(); hit = (log_q.size() == 1); end
    chk("to_first_to", 32'(hit), 1);
    cnt = 0; hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cyc();
      if (grant == 2'b01) cnt++; else hit = 1;
    end
    chk("to_cycles", 32'(cnt), 4);
    chk("to_dead", 32'(grant), 0);
    cyc(); chk("to_next", 32'(grant), 2'b10);
    repeat (6) cyc();

    // Reset while req1 holds the lock with a byte pending.
    do_reset(2);
    q1.push_back(8'h51); q1.push_back(8'h52); q1.push_back(8'h53); q1.push_back(8'h0A);
    en = 2'b10; rdy_in = 0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin cyc(); hit = tx_valid && (grant == 2'b10); end
    chk("mr_setup_to", 32'(hit), 1);
    rst_in = 1; cyc();
    rst_in = 0;
    q0.delete(); q1.delete(); log_q.delete();
    q0.push_back(8'h61); q0.push_back(8'h0A); q1.push_back(8'h62); q1.push_back(8'h0A);
    en = 2'b11; rdy_in = 1;
    cyc();
    chk("mr_txv", 32'(tx_valid), 0);
    chk("mr_grant", 32'(grant), 0);
    repeat (12) cyc();
    chk("mr_count", 32'(log_q.size()), 4);
    if (log_q.size() > 0) chk("mr_first", 32'(log_q[0][15:8]), 0);

    // Randomized traffic against the model.
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() < 4 && $urandom_range(0, 2) == 0)
        q0.push_back(($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom));
      if (q1.size() < 4 && $urandom_range(0, 2) == 0)
        q1.push_back(($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom));
      en[0]  = ($urandom_range(0, 9) < 7);
      en[1]  = ($urandom_range(0, 9) < 7);
      rdy_in = ($urandom_range(0, 3) != 0);
      rst_in = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst_in = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
